// File: rtl/pc_seq_pkg.sv
// Shared constants and types for the next-PC unit.
// Holds the sequential increment and the next-PC source selector.
package pc_seq_pkg;

  localparam int unsigned PC_INC = 4;

  typedef enum logic [1:0] {
    NPC_SEQ,
    NPC_TGT,
    NPC_RAS
  } npc_sel_t;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address LIFO; overwrites its oldest entry when pushed while full.
// Updates on the clock edge; pop wins over push; pop when empty leaves it unchanged.
module ras_stack
  import pc_seq_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_dat,
  output logic [W-1:0] top_dat,
  output logic         empty,
  output logic         full,
  output logic         pop_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_inc;
  logic [PTR_W-1:0] ptr_dec;
  logic [CNT_W-1:0] cnt;

  // ptr names the next free slot, so the top of stack sits one below it
  assign ptr_inc   = (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  assign ptr_dec   = (ptr == '0) ? PTR_W'(DEPTH - 1) : ptr - 1'b1;
  assign top_dat   = mem[ptr_dec];
  assign empty     = (cnt == '0);
  assign full      = (cnt == CNT_W'(DEPTH));
  assign pop_empty = pop & empty;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ptr <= '0;
      cnt <= '0;
    end else if (pop) begin
      if (!empty) begin
        ptr <= ptr_dec;
        cnt <= cnt - 1'b1;
      end
    end else if (push) begin
      ptr <= ptr_inc;
      if (!full) cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET && push && !pop) mem[ptr] <= push_dat;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC unit: target adder, flow-control priority select, PC register and return stack.
// Controls in cycle n set PC in cycle n+1; STALL freezes PC and stack state.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                OFFS_W    = 8,
  parameter int                RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              STALL,
  input  logic              JUMP,
  input  logic              BRANCH,
  input  logic              BNE,
  input  logic              ZERO,
  input  logic              CALL,
  input  logic              RET,
  input  logic [OFFS_W-1:0] OFFSET,
  output logic [ADDR_W-1:0] PC,
  output logic [ADDR_W-1:0] PC_SEQ,
  output logic              TAKEN,
  output logic              RAS_EMPTY,
  output logic              RAS_FULL,
  output logic              RAS_UNF,
  output logic              RAS_OVF
);

  logic [ADDR_W-1:0] offs_ext;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] npc;
  logic [ADDR_W-1:0] ras_top;
  npc_sel_t          sel;
  logic              push_req;
  logic              ras_push;
  logic              ras_pop;
  logic              ras_empty;
  logic              ras_full;
  logic              ras_pop_empty;

  assign offs_ext = {{(ADDR_W - OFFS_W){OFFSET[OFFS_W-1]}}, OFFSET};
  assign PC_SEQ   = PC + ADDR_W'(PC_INC);
  assign target   = PC_SEQ + (offs_ext << 2);

  always_comb begin
    sel      = NPC_SEQ;
    push_req = 1'b0;
    if (RET) begin
      if (!ras_empty) sel = NPC_RAS;
    end else if (CALL) begin
      sel      = NPC_TGT;
      push_req = 1'b1;
    end else if (JUMP || (BRANCH && (ZERO != BNE))) begin
      sel = NPC_TGT;
    end
  end

  always_comb begin
    case (sel)
      NPC_TGT: npc = target;
      NPC_RAS: npc = ras_top;
      default: npc = PC_SEQ;
    endcase
  end

  assign TAKEN    = (sel != NPC_SEQ);
  assign ras_push = push_req & ~STALL;
  assign ras_pop  = RET & ~STALL;

  ras_stack #(
    .W     (ADDR_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .CLK       (CLK),
    .RESET     (RESET),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_dat  (PC_SEQ),
    .top_dat   (ras_top),
    .empty     (ras_empty),
    .full      (ras_full),
    .pop_empty (ras_pop_empty)
  );

  assign RAS_EMPTY = ras_empty;
  assign RAS_FULL  = ras_full;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      PC      <= RESET_PC;
      RAS_UNF <= 1'b0;
      RAS_OVF <= 1'b0;
    end else begin
      if (!STALL) PC <= npc;
      RAS_UNF <= ras_pop_empty;
      RAS_OVF <= ras_push & ras_full;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus a randomized run against a queue-based model.
module tb_pc_sequencer;

  logic        CLK = 1'b0;
  logic        RESET, STALL, JUMP, BRANCH, BNE, ZERO, CALL, RET;
  logic [7:0]  OFFSET;
  logic [31:0] PC, PC_SEQ;
  logic        TAKEN, RAS_EMPTY, RAS_FULL, RAS_UNF, RAS_OVF;

  logic        w_reset;
  logic [7:0]  w_pc, w_pc_seq;
  logic        w_taken, w_empty, w_full, w_unf, w_ovf;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] cur;

  always #5 CLK = ~CLK;

  pc_sequencer #(
    .ADDR_W(32), .OFFS_W(8), .RAS_DEPTH(4), .RESET_PC(32'h100)
  ) dut (
    .CLK(CLK), .RESET(RESET), .STALL(STALL), .JUMP(JUMP), .BRANCH(BRANCH),
    .BNE(BNE), .ZERO(ZERO), .CALL(CALL), .RET(RET), .OFFSET(OFFSET),
    .PC(PC), .PC_SEQ(PC_SEQ), .TAKEN(TAKEN), .RAS_EMPTY(RAS_EMPTY),
    .RAS_FULL(RAS_FULL), .RAS_UNF(RAS_UNF), .RAS_OVF(RAS_OVF)
  );

  pc_sequencer #(
    .ADDR_W(8), .OFFS_W(6), .RAS_DEPTH(2), .RESET_PC(8'hFC)
  ) dut_w8 (
    .CLK(CLK), .RESET(w_reset), .STALL(1'b0), .JUMP(1'b0), .BRANCH(1'b0),
    .BNE(1'b0), .ZERO(1'b0), .CALL(1'b0), .RET(1'b0), .OFFSET(6'd0),
    .PC(w_pc), .PC_SEQ(w_pc_seq), .TAKEN(w_taken), .RAS_EMPTY(w_empty),
    .RAS_FULL(w_full), .RAS_UNF(w_unf), .RAS_OVF(w_ovf)
  );

  task automatic idle();
    STALL = 0; JUMP = 0; BRANCH = 0; BNE = 0; ZERO = 0; CALL = 0; RET = 0; OFFSET = 8'd0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Relative jump from the bench-tracked PC to a nearby address
  task automatic goto(input logic [31:0] a);
    logic signed [31:0] d;
    d = $signed(a - cur - 32'd4) >>> 2;
    idle();
    JUMP = 1; OFFSET = d[7:0];
    tick();
    idle();
    cur = a;
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc;
    idle();
    RESET = 1;
    tick();
    RESET = 0;
    n_cmp++; if (PC !== 32'h100) begin n_bad++; $display("FAIL reset_pc: got %h want %h", PC, 32'h100); end
    n_cmp++; if (RAS_EMPTY !== 1'b1 || RAS_FULL !== 1'b0) begin n_bad++; $display("FAIL reset_flags: empty %b full %b want 1 0", RAS_EMPTY, RAS_FULL); end
    n_cmp++; if (RAS_UNF !== 1'b0 || RAS_OVF !== 1'b0) begin n_bad++; $display("FAIL reset_pulses: unf %b ovf %b want 0 0", RAS_UNF, RAS_OVF); end
    n_cmp++; if (TAKEN !== 1'b0) begin n_bad++; $display("FAIL idle_taken: got %b want 0", TAKEN); end
    exp_pc = 32'h100;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_pc = exp_pc + 32'd4;
      n_cmp++; if (PC !== exp_pc) begin n_bad++; $display("FAIL seq_pc[%0d]: got %h want %h", i, PC, exp_pc); end
      n_cmp++; if (RAS_EMPTY !== 1'b1) begin n_bad++; $display("FAIL seq_empty[%0d]: got %b want 1", i, RAS_EMPTY); end
    end
    cur = 32'h10C;
  endtask

  task automatic test_jump_branch();
    goto(32'h20);
    JUMP = 1; OFFSET = 8'hFE;
    #1;
    n_cmp++; if (TAKEN !== 1'b1) begin n_bad++; $display("FAIL jump_taken: got %b want 1", TAKEN); end
    tick(); idle();
    n_cmp++; if (PC !== 32'h1C) begin n_bad++; $display("FAIL jump_back: got %h want %h", PC, 32'h1C); end
    cur = 32'h1C;
    goto(32'h40);
    BRANCH = 1; BNE = 0; ZERO = 1; OFFSET = 8'h03;
    #1;
    n_cmp++; if (TAKEN !== 1'b1) begin n_bad++; $display("FAIL beq_taken: got %b want 1", TAKEN); end
    tick(); idle();
    n_cmp++; if (PC !== 32'h50) begin n_bad++; $display("FAIL beq_pc: got %h want %h", PC, 32'h50); end
    cur = 32'h50;
    goto(32'h40);
    BRANCH = 1; BNE = 0; ZERO = 0; OFFSET = 8'h03;
    #1;
    n_cmp++; if (TAKEN !== 1'b0) begin n_bad++; $display("FAIL beq_not_taken: got %b want 0", TAKEN); end
    tick(); idle();
    n_cmp++; if (PC !== 32'h44) begin n_bad++; $display("FAIL beq_fall_pc: got %h want %h", PC, 32'h44); end
    cur = 32'h44;
    goto(32'h40);
    BRANCH = 1; BNE = 1; ZERO = 0; OFFSET = 8'h03;
    tick(); idle();
    n_cmp++; if (PC !== 32'h50) begin n_bad++; $display("FAIL bne_pc: got %h want %h", PC, 32'h50); end
    cur = 32'h50;
  endtask

  task automatic test_call_ret();
    goto(32'h10);
    CALL = 1; OFFSET = 8'd4;
    tick(); idle();
    n_cmp++; if (PC !== 32'h24 || RAS_EMPTY !== 1'b0) begin n_bad++; $display("FAIL call1: pc %h empty %b want 24 0", PC, RAS_EMPTY); end
    CALL = 1; OFFSET = 8'd2;
    tick(); idle();
    n_cmp++; if (PC !== 32'h30) begin n_bad++; $display("FAIL call2: got %h want %h", PC, 32'h30); end
    RET = 1;
    #1;
    n_cmp++; if (TAKEN !== 1'b1) begin n_bad++; $display("FAIL ret_taken: got %b want 1", TAKEN); end
    tick(); idle();
    n_cmp++; if (PC !== 32'h28) begin n_bad++; $display("FAIL ret1: got %h want %h", PC, 32'h28); end
    RET = 1;
    tick(); idle();
    n_cmp++; if (PC !== 32'h14 || RAS_EMPTY !== 1'b1) begin n_bad++; $display("FAIL ret2: pc %h empty %b want 14 1", PC, RAS_EMPTY); end
    cur = 32'h14;
  endtask

  task automatic test_overflow();
    logic [31:0] pushed [5];
    for (int i = 0; i < 5; i++) begin
      pushed[i] = cur + 32'd4;
      CALL = 1; OFFSET = 8'd1;
      tick(); idle();
      cur = cur + 32'd8;
      n_cmp++; if (PC !== cur) begin n_bad++; $display("FAIL ovf_call_pc[%0d]: got %h want %h", i, PC, cur); end
      n_cmp++; if (RAS_OVF !== (i == 4)) begin n_bad++; $display("FAIL ovf_pulse[%0d]: got %b want %b", i, RAS_OVF, (i == 4)); end
      n_cmp++; if (RAS_FULL !== (i >= 3)) begin n_bad++; $display("FAIL ovf_full[%0d]: got %b want %b", i, RAS_FULL, (i >= 3)); end
    end
    for (int j = 0; j < 4; j++) begin
      RET = 1;
      tick(); idle();
      n_cmp++; if (PC !== pushed[4-j]) begin n_bad++; $display("FAIL ovf_ret[%0d]: got %h want %h", j, PC, pushed[4-j]); end
      n_cmp++; if (RAS_OVF !== 1'b0 || RAS_UNF !== 1'b0) begin n_bad++; $display("FAIL ovf_ret_pulses[%0d]: ovf %b unf %b want 0 0", j, RAS_OVF, RAS_UNF); end
    end
    n_cmp++; if (RAS_EMPTY !== 1'b1) begin n_bad++; $display("FAIL ovf_drained: got %b want 1", RAS_EMPTY); end
    cur = pushed[1];
  endtask

  task automatic test_underflow();
    goto(32'h60);
    RET = 1;
    #1;
    n_cmp++; if (TAKEN !== 1'b0) begin n_bad++; $display("FAIL unf_taken: got %b want 0", TAKEN); end
    tick(); idle();
    n_cmp++; if (PC !== 32'h64 || RAS_UNF !== 1'b1) begin n_bad++; $display("FAIL unf_edge: pc %h unf %b want 64 1", PC, RAS_UNF); end
    tick();
    n_cmp++; if (PC !== 32'h68 || RAS_UNF !== 1'b0) begin n_bad++; $display("FAIL unf_clear: pc %h unf %b want 68 0", PC, RAS_UNF); end
    cur = 32'h68;
  endtask

  task automatic test_stall();
    CALL = 1; OFFSET = 8'd4;
    tick(); idle();
    n_cmp++; if (PC !== 32'h7C) begin n_bad++; $display("FAIL stall_pre_call: got %h want %h", PC, 32'h7C); end
    for (int i = 0; i < 2; i++) begin
      STALL = 1; CALL = 1; OFFSET = 8'd4;
      #1;
      n_cmp++; if (TAKEN !== 1'b1) begin n_bad++; $display("FAIL stall_taken[%0d]: got %b want 1", i, TAKEN); end
      tick();
      n_cmp++; if (PC !== 32'h7C || RAS_OVF !== 1'b0) begin n_bad++; $display("FAIL stall_hold[%0d]: pc %h ovf %b want 7c 0", i, PC, RAS_OVF); end
    end
    idle();
    RET = 1;
    tick(); idle();
    n_cmp++; if (PC !== 32'h6C || RAS_EMPTY !== 1'b1) begin n_bad++; $display("FAIL stall_count: pc %h empty %b want 6c 1", PC, RAS_EMPTY); end
    cur = 32'h6C;
  endtask

  task automatic test_reset_call();
    CALL = 1; OFFSET = 8'd1;
    tick();
    RESET = 1; CALL = 1; OFFSET = 8'd1;
    tick();
    RESET = 0; idle();
    n_cmp++; if (PC !== 32'h100 || RAS_EMPTY !== 1'b1) begin n_bad++; $display("FAIL reset_call: pc %h empty %b want 100 1", PC, RAS_EMPTY); end
    cur = 32'h100;
  endtask

  task automatic test_wrap();
    w_reset = 1;
    tick();
    w_reset = 0;
    n_cmp++; if (w_pc !== 8'hFC || w_pc_seq !== 8'h00) begin n_bad++; $display("FAIL wrap_pre: pc %h seq %h want fc 00", w_pc, w_pc_seq); end
    tick();
    n_cmp++; if (w_pc !== 8'h00) begin n_bad++; $display("FAIL wrap_pc: got %h want 00", w_pc); end
  endtask

  task automatic test_random();
    logic [31:0] m_pc, seq, tgt, nxt;
    logic [31:0] m_q[$];
    logic        m_unf, m_ovf, exp_taken;
    int          o;
    RESET = 1; idle();
    tick();
    RESET = 0;
    m_pc = 32'h100; m_q = {}; m_unf = 0; m_ovf = 0;
    for (int c = 0; c < 600; c++) begin
      RESET  = ($urandom_range(39) == 0);
      STALL  = ($urandom_range(5) == 0);
      RET    = ($urandom_range(4) == 0);
      CALL   = ($urandom_range(3) == 0);
      JUMP   = ($urandom_range(4) == 0);
      BRANCH = ($urandom_range(2) == 0);
      BNE    = $urandom_range(1);
      ZERO   = $urandom_range(1);
      OFFSET = 8'($urandom);
      #1;
      o   = $signed(OFFSET);
      seq = m_pc + 32'd4;
      tgt = seq + 32'(o * 4);
      if (RET) begin
        exp_taken = (m_q.size() != 0);
        nxt = exp_taken ? m_q[$] : seq;
      end else if (CALL || JUMP || (BRANCH && (BNE ? !ZERO : ZERO))) begin
        exp_taken = 1; nxt = tgt;
      end else begin
        exp_taken = 0; nxt = seq;
      end
      n_cmp++; if (TAKEN !== exp_taken) begin n_bad++; $display("FAIL rnd_taken[%0d]: got %b want %b", c, TAKEN, exp_taken); end
      n_cmp++; if (PC_SEQ !== seq) begin n_bad++; $display("FAIL rnd_seq[%0d]: got %h want %h", c, PC_SEQ, seq); end
      m_unf = 0; m_ovf = 0;
      if (RESET) begin
        m_pc = 32'h100; m_q = {};
      end else if (!STALL) begin
        if (RET) begin
          if (m_q.size() != 0) void'(m_q.pop_back());
          else m_unf = 1;
        end else if (CALL) begin
          if (m_q.size() == 4) begin
            m_q.delete(0);
            m_ovf = 1;
          end
          m_q.push_back(seq);
        end
        m_pc = nxt;
      end
      tick();
      n_cmp++; if (PC !== m_pc) begin n_bad++; $display("FAIL rnd_pc[%0d]: got %h want %h", c, PC, m_pc); end
      n_cmp++; if (RAS_EMPTY !== (m_q.size() == 0) || RAS_FULL !== (m_q.size() == 4)) begin
        n_bad++; $display("FAIL rnd_flags[%0d]: empty %b full %b want depth %0d", c, RAS_EMPTY, RAS_FULL, m_q.size());
      end
      n_cmp++; if (RAS_UNF !== m_unf || RAS_OVF !== m_ovf) begin
        n_bad++; $display("FAIL rnd_pulses[%0d]: unf %b ovf %b want %b %b", c, RAS_UNF, RAS_OVF, m_unf, m_ovf);
      end
    end
    RESET = 0; idle();
  endtask

  initial begin
    RESET = 1; w_reset = 1; cur = 32'h100;
    idle();
    test_reset();
    test_jump_branch();
    test_call_ret();
    test_overflow();
    test_underflow();
    test_stall();
    test_reset_call();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
